// File: rtl/mul_acc_pkg.sv
// Shared definitions for the multiply-accumulate stage that sits behind the
// 8-bit multiplier.
//   PROD_W          : width of the unsigned product coming from the multiplier
//   mul_acc_state_e : accumulator FSM states
//   cnt_w()         : width of a counter able to hold 0..WIN inclusive
package mul_acc_pkg;

    localparam int PROD_W = 16;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } mul_acc_state_e;

    function automatic int cnt_w(input int win);
        return $clog2(win + 1);
    endfunction

endpackage

// File: rtl/mul_acc_sat_add.sv
// Combinational saturating adder: acc + zero-extended product.
// Ports:
//   acc [ACC_W-1:0]  : current running sum
//   mul [PROD_W-1:0] : unsigned product to add
//   sum [ACC_W-1:0]  : acc + mul, clamped to all-ones on carry out
//   sat              : the add carried out of ACC_W bits
module mul_acc_sat_add
    import mul_acc_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] mul,
    output logic [ACC_W-1:0]  sum,
    output logic              sat
);

    logic [ACC_W:0] wide;

    // One guard bit above the accumulator catches the carry; ACC_W >= PROD_W
    // so the zero-extension pad is always at least one bit.
    assign wide = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, mul};
    assign sat  = wide[ACC_W];
    assign sum  = sat ? {ACC_W{1'b1}} : wide[ACC_W-1:0];

endmodule

// File: rtl/mul_acc.sv
// Windowed saturating accumulator for multiplier products.
// Sums WIN accepted products, then presents the sum until the consumer takes it.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : product handshake (mul)
//   mul [15:0]          : unsigned product
//   clear               : synchronous abort of the current window / pending output
//   out_valid/out_ready : result handshake (acc_out, ovf)
//   acc_out [ACC_W-1:0] : saturated window sum
//   ovf                 : window saturated (only while out_valid)
//   dbg_state           : current FSM state, for observation only
// Handshake rule (both sides): a transfer happens on the rising edge where
// valid && ready; valid, once raised, holds with stable data until that
// transfer (or clear/rst), and ready never depends on the same-side valid.
module mul_acc
    import mul_acc_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int WIN   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PROD_W-1:0]  mul,
    input  logic               clear,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   acc_out,
    output logic               ovf,
    output mul_acc_state_e     dbg_state
);

    localparam int            CW       = cnt_w(WIN);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIN - 1);

    mul_acc_state_e   state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sticky_q, sticky_d;
    logic [ACC_W-1:0] acc_out_q, acc_out_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_sat;

    mul_acc_sat_add #(.ACC_W(ACC_W)) u_add (
        .acc (acc_q),
        .mul (mul),
        .sum (add_sum),
        .sat (add_sat)
    );

    // Ready depends on state and reset only.
    assign in_ready  = (state_q == ACCUM) && !rst;
    assign out_valid = out_valid_q;
    assign acc_out   = acc_out_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        acc_out_d   = acc_out_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        if (clear) begin
            // Abort wins over any handshake in the same cycle: an offered
            // product is dropped and a pending result is discarded.
            state_d     = ACCUM;
            cnt_d       = '0;
            acc_d       = '0;
            sticky_d    = 1'b0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        acc_d    = add_sum;
                        sticky_d = sticky_q | add_sat;
                        cnt_d    = cnt_q + CW'(1);
                        if (cnt_q == LAST_CNT) begin
                            acc_out_d   = add_sum;
                            ovf_d       = sticky_q | add_sat;
                            out_valid_d = 1'b1;
                            state_d     = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        acc_d       = '0;
                        cnt_d       = '0;
                        sticky_d    = 1'b0;
                        ovf_d       = 1'b0;
                        state_d     = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            acc_out_q   <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            acc_out_q   <= acc_out_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_mul_acc.sv
// Bench for mul_acc: three instances (WIN=4/ACC_W=24, WIN=4/ACC_W=17,
// WIN=1/ACC_W=24) share the control inputs; sel routes in_valid to one of
// them and muxes that instance's outputs back.
module tb_mul_acc;
    import mul_acc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] mul;
    logic        clear;
    logic        out_ready;
    logic [1:0]  sel;

    always #5 clk = ~clk;

    // Per-instance wiring
    logic           iv0, iv1, iv2;
    logic           ir0, ir1, ir2;
    logic           ov0, ov1, ov2;
    logic           of0, of1, of2;
    logic [23:0]    ao0, ao2;
    logic [16:0]    ao1;
    mul_acc_state_e st0, st1, st2;

    assign iv0 = in_valid && (sel == 2'd0);
    assign iv1 = in_valid && (sel == 2'd1);
    assign iv2 = in_valid && (sel == 2'd2);

    mul_acc #(.ACC_W(24), .WIN(4)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .mul(mul),
        .clear(clear), .out_valid(ov0), .out_ready(out_ready),
        .acc_out(ao0), .ovf(of0), .dbg_state(st0)
    );

    mul_acc #(.ACC_W(17), .WIN(4)) u_sat (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .mul(mul),
        .clear(clear), .out_valid(ov1), .out_ready(out_ready),
        .acc_out(ao1), .ovf(of1), .dbg_state(st1)
    );

    mul_acc #(.ACC_W(24), .WIN(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .mul(mul),
        .clear(clear), .out_valid(ov2), .out_ready(out_ready),
        .acc_out(ao2), .ovf(of2), .dbg_state(st2)
    );

    logic           cur_ready, cur_valid, cur_ovf;
    logic [23:0]    cur_acc;
    mul_acc_state_e cur_state;

    always_comb begin
        cur_ready = ir0;
        cur_valid = ov0;
        cur_ovf   = of0;
        cur_acc   = ao0;
        cur_state = st0;
        case (sel)
            2'd1: begin
                cur_ready = ir1; cur_valid = ov1; cur_ovf = of1;
                cur_acc = {7'd0, ao1}; cur_state = st1;
            end
            2'd2: begin
                cur_ready = ir2; cur_valid = ov2; cur_ovf = of2;
                cur_acc = ao2; cur_state = st2;
            end
            default: ;
        endcase
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Offer one product and return #1 after the edge that accepts it.
    task automatic send(input logic [15:0] p);
        int t;
        t = 0;
        in_valid = 1'b1;
        mul      = p;
        @(negedge clk);
        while (!cur_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!cur_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for product %0d", p);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [1:0]       sel;
        int               n;
        logic [3:0][15:0] p;
        logic [23:0]      exp_acc;
        logic             exp_ovf;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] s, input int n, input int a, input int b,
                                input int c, input int d, input int acc, input logic o);
        vec_t v;
        v.sel     = s;
        v.n       = n;
        v.p[0]    = 16'(a);
        v.p[1]    = 16'(b);
        v.p[2]    = 16'(c);
        v.p[3]    = 16'(d);
        v.exp_acc = 24'(acc);
        v.exp_ovf = o;
        return v;
    endfunction

    // Full window with out_ready=1: output visible right after the last
    // accept, accepted on the next edge, then in_ready returns.
    task automatic run_window(input string tag, input vec_t v);
        sel       = v.sel;
        out_ready = 1'b1;
        for (int i = 0; i < v.n; i++) begin
            if (i > 0) chk({tag, "_early_valid"}, 32'(cur_valid), 32'd0);
            send(v.p[i]);
        end
        chk({tag, "_valid"}, 32'(cur_valid), 32'd1);
        chk({tag, "_acc"}, 32'(cur_acc), 32'(v.exp_acc));
        chk({tag, "_ovf"}, 32'(cur_ovf), 32'(v.exp_ovf));
        chk({tag, "_hold_ready"}, 32'(cur_ready), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_valid_drop"}, 32'(cur_valid), 32'd0);
        chk({tag, "_ovf_drop"}, 32'(cur_ovf), 32'd0);
        chk({tag, "_ready_back"}, 32'(cur_ready), 32'd1);
    endtask

    vec_t vecs[10];
    vec_t tmp;

    initial begin
        rst = 1'b1; in_valid = 1'b0; mul = '0; clear = 1'b0;
        out_ready = 1'b1; sel = 2'd0;

        vecs[0] = mk(2'd0, 4, 1, 2, 3, 4, 10, 1'b0);
        vecs[1] = mk(2'd0, 4, 0, 0, 0, 0, 0, 1'b0);
        vecs[2] = mk(2'd0, 4, 65535, 65535, 65535, 65535, 262140, 1'b0);
        vecs[3] = mk(2'd1, 4, 65025, 65025, 65025, 7, 131071, 1'b1);
        vecs[4] = mk(2'd1, 4, 1, 1, 1, 1, 4, 1'b0);
        vecs[5] = mk(2'd1, 4, 65535, 65535, 1, 0, 131071, 1'b0);
        vecs[6] = mk(2'd1, 4, 65535, 65535, 2, 0, 131071, 1'b1);
        vecs[7] = mk(2'd2, 1, 65025, 0, 0, 0, 65025, 1'b0);
        vecs[8] = mk(2'd2, 1, 3, 0, 0, 0, 3, 1'b0);
        vecs[9] = mk(2'd2, 1, 0, 0, 0, 0, 0, 1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            chk($sformatf("rst_ready_%0d", s), 32'(cur_ready), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            chk($sformatf("post_rst_ready_%0d", s), 32'(cur_ready), 32'd1);
            chk($sformatf("post_rst_valid_%0d", s), 32'(cur_valid), 32'd0);
            chk($sformatf("post_rst_acc_%0d", s), 32'(cur_acc), 32'd0);
            chk($sformatf("post_rst_ovf_%0d", s), 32'(cur_ovf), 32'd0);
            chk($sformatf("post_rst_state_%0d", s), 32'(cur_state), 32'(ACCUM));
        end

        // Table of full windows
        foreach (vecs[i]) run_window($sformatf("vec%0d", i), vecs[i]);

        // Saturation trace of the internal accumulator
        sel = 2'd1; out_ready = 1'b0;
        send(16'd65025); chk("sat_acc1", 32'(u_sat.acc_q), 32'd65025);
        send(16'd65025); chk("sat_acc2", 32'(u_sat.acc_q), 32'd130050);
        send(16'd65025); chk("sat_acc3", 32'(u_sat.acc_q), 32'd131071);
        send(16'd7);     chk("sat_acc4", 32'(u_sat.acc_q), 32'd131071);
        chk("sat_out", 32'(cur_acc), 32'd131071);
        chk("sat_ovf", 32'(cur_ovf), 32'd1);
        chk("sat_state", 32'(cur_state), 32'(HOLD));
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Backpressure: result held for 6 cycles, then accepted
        sel = 2'd0; out_ready = 1'b0;
        send(16'd1); send(16'd2); send(16'd3); send(16'd4);
        for (int k = 0; k < 6; k++) begin
            if (k == 5) out_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("bp_valid_%0d", k), 32'(cur_valid), 32'd1);
            chk($sformatf("bp_acc_%0d", k), 32'(cur_acc), 32'd10);
            chk($sformatf("bp_ready_%0d", k), 32'(cur_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("bp_valid_drop", 32'(cur_valid), 32'd0);
        chk("bp_ready_next", 32'(cur_ready), 32'd1);
        tmp = mk(2'd0, 4, 5, 6, 7, 8, 26, 1'b0);
        run_window("bp_next", tmp);

        // Clear mid-window drops the sum and the product offered with it
        sel = 2'd0;
        send(16'd100); send(16'd200);
        in_valid = 1'b1; mul = 16'd50; clear = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; clear = 1'b0;
        chk("clr_mid_valid", 32'(cur_valid), 32'd0);
        chk("clr_mid_ready", 32'(cur_ready), 32'd1);
        tmp = mk(2'd0, 4, 1, 2, 3, 4, 10, 1'b0);
        run_window("clr_mid", tmp);

        // Clear in HOLD discards the pending result
        out_ready = 1'b0;
        send(16'd1); send(16'd2); send(16'd3); send(16'd4);
        chk("clr_hold_pre", 32'(cur_valid), 32'd1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clr_hold_valid", 32'(cur_valid), 32'd0);
        chk("clr_hold_ready", 32'(cur_ready), 32'd1);
        chk("clr_hold_state", 32'(cur_state), 32'(ACCUM));
        tmp = mk(2'd0, 4, 2, 2, 2, 2, 8, 1'b0);
        run_window("clr_hold", tmp);

        // Clear in HOLD on a saturated window also drops ovf
        sel = 2'd1; out_ready = 1'b0;
        send(16'd65535); send(16'd65535); send(16'd65535); send(16'd65535);
        chk("clr_ovf_pre", 32'(cur_ovf), 32'd1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clr_ovf_post", 32'(cur_ovf), 32'd0);
        tmp = mk(2'd1, 4, 1, 1, 1, 1, 4, 1'b0);
        run_window("clr_ovf_next", tmp);

        // Reset mid-window loses the partial sum
        sel = 2'd0;
        send(16'd5); send(16'd5);
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(cur_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(cur_valid), 32'd0);
        chk("rst_mid_acc", 32'(cur_acc), 32'd0);
        chk("rst_mid_ovf", 32'(cur_ovf), 32'd0);
        chk("rst_mid_ready_after", 32'(cur_ready), 32'd1);
        tmp = mk(2'd0, 4, 5, 5, 5, 5, 20, 1'b0);
        run_window("rst_mid", tmp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
